// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - shared-bus arbiter moving packets between device FIFOs
// Grants one pending FIFO per transaction (fixed priority or round robin), then unicasts or broadcasts its head packet.
module bus_arbiter_rr #(
  parameter int         pckg_sz   = 24,
  parameter int         drvrs     = 16,
  parameter logic [7:0] BROADCAST = 8'hFF,
  parameter int         MAX_WAIT  = 16,
  parameter int         CNT_W     = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [drvrs-1:0]                pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
  input  logic [drvrs-1:0]                rdy,
  input  logic                            mode,
  output logic [drvrs-1:0]                pop,
  output logic [drvrs-1:0]                push,
  output logic [pckg_sz-1:0]              D_push,
  output logic                            busy,
  output logic [CNT_W-1:0]                drop_cnt
);

  localparam int IW = $clog2(drvrs);
  localparam int WW = $clog2(MAX_WAIT + 2);
  localparam logic [IW-1:0]    LAST_RST = IW'(drvrs - 1);
  localparam logic [drvrs-1:0] ONE      = drvrs'(1);
  localparam logic [WW-1:0]    W_ONE    = WW'(1);
  localparam logic [WW-1:0]    W_MAX    = WW'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      gnt_q, gnt_d, last_q, last_d;
  logic [IW-1:0]      win, win_hi, win_lo;
  logic               found_hi;
  logic [pckg_sz-1:0] pkt_q, pkt_d, dpush_q, dpush_d;
  logic [drvrs-1:0]   pop_q, pop_d, push_q, push_d, need;
  logic [WW-1:0]      wait_q, wait_d, wait_inc;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic [7:0]         dst;
  logic               is_bcast, invalid, do_drop;

  // Descending scan leaves the lowest requester overall in win_lo and the lowest above last in win_hi;
  // round robin wraps to win_lo when nothing above last is pending.
  always_comb begin
    win_lo   = '0;
    win_hi   = '0;
    found_hi = 1'b0;
    for (int i = drvrs - 1; i >= 0; i--) begin
      if (pndng[i]) begin
        win_lo = IW'(i);
        if (i > int'(last_q)) begin
          win_hi   = IW'(i);
          found_hi = 1'b1;
        end
      end
    end
    win = (mode && found_hi) ? win_hi : win_lo;
  end

  assign dst      = pkt_q[pckg_sz-1 -: 8];
  assign is_bcast = (dst == BROADCAST);
  assign invalid  = (!is_bcast && int'(dst) >= drvrs) || (int'(dst) == int'(gnt_q));
  assign need     = is_bcast ? ~(ONE << gnt_q) : (ONE << dst);
  assign wait_inc = wait_q + W_ONE;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    pkt_d   = pkt_q;
    dpush_d = dpush_q;
    wait_d  = wait_q;
    drop_d  = drop_q;
    pop_d   = '0;
    push_d  = '0;
    do_drop = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pndng) begin
          gnt_d   = win;
          last_d  = win;
          pkt_d   = D_pop[win];
          pop_d   = ONE << win;
          wait_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (invalid) begin
          do_drop = 1'b1;
          state_d = IDLE;
        end else if ((rdy & need) == need) begin
          push_d  = need;
          dpush_d = pkt_q;
          wait_d  = '0;
          state_d = IDLE;
        end else begin
          wait_d = wait_inc;
          if (MAX_WAIT != 0 && wait_inc == W_MAX) begin
            do_drop = 1'b1;
            wait_d  = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (do_drop && drop_q != '1) drop_d = drop_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= LAST_RST;
      pkt_q   <= '0;
      dpush_q <= '0;
      wait_q  <= '0;
      drop_q  <= '0;
      pop_q   <= '0;
      push_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      pkt_q   <= pkt_d;
      dpush_q <= dpush_d;
      wait_q  <= wait_d;
      drop_q  <= drop_d;
      pop_q   <= pop_d;
      push_q  <= push_d;
    end
  end

  assign pop      = pop_q;
  assign push     = push_q;
  assign D_push   = dpush_q;
  assign busy     = (state_q == SEND);
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb/tb_bus_arbiter_rr.sv - self-checking bench for bus_arbiter_rr
// Directed scenarios plus a randomized run scored against a cycle-level behavioural model.
module tb_bus_arbiter_rr;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [3:0]        pndng = '0, rdy = 4'hF;
  logic [3:0][23:0]  D_pop = '0;
  logic              mode = 1'b1;
  logic [3:0]        pop, push, pop_s, push_s;
  logic [23:0]       D_push, D_push_s;
  logic              busy, busy_s;
  logic [15:0]       drop_cnt;
  logic [1:0]        drop_s;
  int                checks = 0, failures = 0;

  // Random-test FIFO storage
  logic [23:0]       fifo [4][4];
  int                fcnt [4];

  always #5 clk = ~clk;

  bus_arbiter_rr #(.pckg_sz(24), .drvrs(4), .BROADCAST(8'hFF), .MAX_WAIT(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .rdy(rdy), .mode(mode),
    .pop(pop), .push(push), .D_push(D_push), .busy(busy), .drop_cnt(drop_cnt));

  bus_arbiter_rr #(.pckg_sz(24), .drvrs(4), .BROADCAST(8'hFF), .MAX_WAIT(4), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .rdy(rdy), .mode(mode),
    .pop(pop_s), .push(push_s), .D_push(D_push_s), .busy(busy_s), .drop_cnt(drop_s));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; pndng = '0; rdy = 4'hF; mode = 1'b1; D_pop = '0;
    cyc(); cyc();
    reset = 1'b1;
  endtask

  function automatic int pick(logic [3:0] p, logic m, int last);
    if (!m) begin
      for (int i = 0; i < 4; i++) if (p[i]) return i;
    end else begin
      for (int k = 1; k <= 4; k++) if (p[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b0; pndng = 4'hF; D_pop = '0;
    cyc();
    checks++; if (pop !== 4'h0) begin failures++; $display("FAIL reset_pop: got %b want 0000", pop); end
    checks++; if (push !== 4'h0) begin failures++; $display("FAIL reset_push: got %b want 0000", push); end
    checks++; if (D_push !== 24'h0) begin failures++; $display("FAIL reset_dpush: got %h want 000000", D_push); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (drop_cnt !== 16'h0) begin failures++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    pndng = '0;
    reset = 1'b1;
  endtask

  task automatic test_rr_fairness();
    logic [3:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) D_pop[i] = {8'((i + 1) % 4), 16'(16'hA000 + i)};
    pndng = 4'hF;
    for (int n = 0; n < 5; n++) begin
      int g;
      g = n % 4;
      cyc();
      e = 4'b0001 << g;
      checks++; if (pop !== e) begin failures++; $display("FAIL rr_pop%0d: got %b want %b", n, pop, e); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rr_busy%0d: got %b want 1", n, busy); end
      cyc();
      e = 4'b0001 << ((g + 1) % 4);
      checks++; if (push !== e) begin failures++; $display("FAIL rr_push%0d: got %b want %b", n, push, e); end
      checks++; if (D_push !== D_pop[g]) begin failures++; $display("FAIL rr_dpush%0d: got %h want %h", n, D_push, D_pop[g]); end
    end
    pndng = '0;
    cyc();
  endtask

  task automatic test_fixed_priority();
    do_reset();
    mode = 1'b0; pndng = 4'b1010;
    D_pop[1] = 24'h00_1111; D_pop[3] = 24'h00_3333; D_pop[2] = 24'h00_2222;
    for (int n = 0; n < 4; n++) begin
      cyc();
      checks++; if (pop !== 4'b0010) begin failures++; $display("FAIL fixed_pop%0d: got %b want 0010", n, pop); end
      cyc();
      checks++; if (push !== 4'b0001 || D_push !== 24'h00_1111) begin
        failures++; $display("FAIL fixed_push%0d: got %b/%h want 0001/001111", n, push, D_push); end
    end
    mode = 1'b1; pndng = 4'hF;
    cyc();
    checks++; if (pop !== 4'b0100) begin failures++; $display("FAIL fixed_last_update: got %b want 0100", pop); end
    pndng = '0;
    cyc(); cyc();
  endtask

  task automatic test_broadcast();
    do_reset();
    D_pop[2] = 24'hFF_1234; pndng = 4'b0100;
    cyc();
    checks++; if (pop !== 4'b0100) begin failures++; $display("FAIL bc_pop: got %b want 0100", pop); end
    pndng = '0;
    cyc();
    checks++; if (push !== 4'b1011) begin failures++; $display("FAIL bc_push: got %b want 1011", push); end
    checks++; if (D_push !== 24'hFF1234) begin failures++; $display("FAIL bc_dpush: got %h want ff1234", D_push); end
    cyc();
    checks++; if (push !== 4'b0000) begin failures++; $display("FAIL bc_push_once: got %b want 0000", push); end
    checks++; if (D_push !== 24'hFF1234) begin failures++; $display("FAIL bc_dpush_hold: got %h want ff1234", D_push); end
  endtask

  task automatic test_backpressure();
    do_reset();
    D_pop[0] = {8'd3, 16'hBEEF}; rdy = 4'b0111; pndng = 4'b0001;
    cyc();
    checks++; if (pop !== 4'b0001) begin failures++; $display("FAIL bp_pop: got %b want 0001", pop); end
    pndng = '0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      checks++; if (push !== 4'b0000 || busy !== 1'b1) begin
        failures++; $display("FAIL bp_stall%0d: got push=%b busy=%b want 0000/1", k, push, busy); end
    end
    rdy = 4'hF;
    cyc();
    checks++; if (push !== 4'b1000 || D_push !== 24'h03BEEF) begin
      failures++; $display("FAIL bp_push: got %b/%h want 1000/03beef", push, D_push); end
    checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL bp_drop: got %0d want 0", drop_cnt); end
    cyc();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_idle: got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    do_reset();
    D_pop[0] = {8'd3, 16'hCAFE}; rdy = 4'b0111; pndng = 4'b0001;
    cyc();
    checks++; if (pop !== 4'b0001) begin failures++; $display("FAIL to_pop: got %b want 0001", pop); end
    pndng = '0;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      checks++; if (push !== 4'b0000 || busy !== 1'b1 || drop_cnt !== 16'd0) begin
        failures++; $display("FAIL to_wait%0d: got push=%b busy=%b drop=%0d want 0000/1/0", k, push, busy, drop_cnt); end
    end
    cyc();
    checks++; if (drop_cnt !== 16'd1 || busy !== 1'b0 || push !== 4'b0000) begin
      failures++; $display("FAIL to_drop: got drop=%0d busy=%b push=%b want 1/0/0000", drop_cnt, busy, push); end
    cyc();
    checks++; if (push !== 4'b0000) begin failures++; $display("FAIL to_nopush: got %b want 0000", push); end
    rdy = 4'hF;
  endtask

  task automatic test_invalid();
    do_reset();
    D_pop[0] = {8'h07, 16'h0001}; pndng = 4'b0001;
    cyc(); pndng = '0; cyc();
    checks++; if (drop_cnt !== 16'd1 || push !== 4'b0000 || busy !== 1'b0) begin
      failures++; $display("FAIL inv_range: got drop=%0d push=%b busy=%b want 1/0000/0", drop_cnt, push, busy); end
    D_pop[0] = {8'h00, 16'h0002}; pndng = 4'b0001;
    cyc(); pndng = '0; cyc();
    checks++; if (drop_cnt !== 16'd2 || push !== 4'b0000) begin
      failures++; $display("FAIL inv_self: got drop=%0d push=%b want 2/0000", drop_cnt, push); end
  endtask

  task automatic test_saturation();
    do_reset();
    D_pop[0] = {8'h07, 16'h0000};
    for (int k = 0; k < 5; k++) begin
      pndng = 4'b0001; cyc(); pndng = '0; cyc();
      checks++; if (push_s !== 4'b0000) begin failures++; $display("FAIL sat_push%0d: got %b want 0000", k, push_s); end
    end
    checks++; if (drop_s !== 2'd3) begin failures++; $display("FAIL sat_cnt: got %0d want 3", drop_s); end
    checks++; if (drop_cnt !== 16'd5) begin failures++; $display("FAIL sat_wide: got %0d want 5", drop_cnt); end
  endtask

  task automatic test_reset_mid_send();
    do_reset();
    D_pop[0] = {8'h07, 16'h0000}; pndng = 4'b0001;
    cyc(); pndng = '0; cyc();
    D_pop[0] = {8'd3, 16'h7777}; rdy = 4'b0111; pndng = 4'b0001;
    cyc();
    checks++; if (pop !== 4'b0001 || busy !== 1'b1 || drop_cnt !== 16'd1) begin
      failures++; $display("FAIL rst_pre: got pop=%b busy=%b drop=%0d want 0001/1/1", pop, busy, drop_cnt); end
    reset = 1'b0;
    #1;
    checks++; if (pop !== 4'b0000 || busy !== 1'b0 || drop_cnt !== 16'd0 || push !== 4'b0000) begin
      failures++; $display("FAIL rst_async: got pop=%b busy=%b drop=%0d push=%b want 0", pop, busy, drop_cnt, push); end
    rdy = 4'hF; pndng = 4'hF;
    for (int i = 0; i < 4; i++) D_pop[i] = {8'((i + 1) % 4), 16'h5500};
    cyc();
    reset = 1'b1;
    cyc();
    checks++; if (pop !== 4'b0001) begin failures++; $display("FAIL rst_first_gnt: got %b want 0001", pop); end
    pndng = '0;
    cyc();
    checks++; if (push !== 4'b0010 || D_push !== 24'h015500) begin
      failures++; $display("FAIL rst_no_abort_push: got %b/%h want 0010/015500", push, D_push); end
    cyc();
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      pndng[i] = (fcnt[i] != 0);
      D_pop[i] = (fcnt[i] != 0) ? fifo[i][0] : 24'h0;
    end
  endtask

  task automatic test_random();
    logic        m_send;
    int          m_src, m_last, m_wait, m_drops, g, nerr;
    logic [23:0] m_pkt, m_dpush;
    logic [3:0]  pin, rin, e_pop, e_push, need;
    logic        min;
    logic [7:0]  dst;
    do_reset();
    m_send = 1'b0; m_last = 3; m_wait = 0; m_drops = 0; m_dpush = '0; m_src = 0; m_pkt = '0; nerr = 0;
    for (int i = 0; i < 4; i++) fcnt[i] = 0;
    refresh();
    for (int c = 0; c < 1500; c++) begin
      pin = pndng; rin = rdy; min = mode;
      e_pop = '0; e_push = '0;
      if (!m_send) begin
        if (pin != 0) begin
          g = pick(pin, min, m_last);
          e_pop = 4'b0001 << g;
          m_send = 1'b1; m_src = g; m_pkt = D_pop[g]; m_wait = 0; m_last = g;
        end
      end else begin
        dst = m_pkt[23:16];
        if (dst == 8'hFF) need = 4'hF & ~(4'b0001 << m_src);
        else if (dst < 8'd4 && int'(dst) != m_src) need = 4'b0001 << dst;
        else need = 4'h0;
        if (need == 4'h0) begin
          m_drops++; m_send = 1'b0;
        end else if ((rin & need) == need) begin
          e_push = need; m_dpush = m_pkt; m_send = 1'b0;
        end else begin
          m_wait++;
          if (m_wait == 4) begin m_drops++; m_send = 1'b0; end
        end
      end
      cyc();
      checks++; if (pop !== e_pop) begin failures++; nerr++; $display("FAIL rnd_pop c%0d: got %b want %b", c, pop, e_pop); end
      checks++; if (push !== e_push) begin failures++; nerr++; $display("FAIL rnd_push c%0d: got %b want %b", c, push, e_push); end
      checks++; if (D_push !== m_dpush) begin failures++; nerr++; $display("FAIL rnd_dpush c%0d: got %h want %h", c, D_push, m_dpush); end
      checks++; if (busy !== m_send) begin failures++; nerr++; $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, m_send); end
      checks++; if (drop_cnt !== 16'(m_drops)) begin failures++; nerr++; $display("FAIL rnd_drop c%0d: got %0d want %0d", c, drop_cnt, m_drops); end
      checks++; if (drop_s !== 2'(m_drops > 3 ? 3 : m_drops)) begin
        failures++; nerr++; $display("FAIL rnd_drop_sat c%0d: got %0d want %0d", c, drop_s, m_drops); end
      if (nerr > 20) begin
        $display("FAIL rnd_abort: too many errors at cycle %0d", c);
        break;
      end
      if (e_pop != 0) begin
        for (int k = 0; k < 3; k++) fifo[m_src][k] = fifo[m_src][k + 1];
        fcnt[m_src]--;
      end
      begin
        int d, r;
        logic [7:0] nd;
        d = $urandom_range(0, 3);
        if ($urandom_range(0, 1) == 1 && fcnt[d] < 4) begin
          r = $urandom_range(0, 9);
          if (r <= 5) nd = 8'($urandom_range(0, 3));
          else if (r <= 7) nd = 8'hFF;
          else if (r == 8) nd = 8'h07;
          else nd = 8'($urandom_range(0, 255));
          fifo[d][fcnt[d]] = {nd, 16'($urandom)};
          fcnt[d]++;
        end
      end
      if ((c % 64) >= 52) rdy = 4'($urandom_range(0, 15)) & 4'b0110;
      else if ($urandom_range(0, 9) < 6) rdy = 4'hF;
      else rdy = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      refresh();
    end
    pndng = '0; rdy = 4'hF;
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_fixed_priority();
    test_broadcast();
    test_backpressure();
    test_timeout();
    test_invalid();
    test_saturation();
    test_reset_mid_send();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
